// File: rtl/irda_pkg.sv
// rtl/irda_pkg.sv - shared IrDA SIR bit timing constants and decoder state type
package irda_pkg;

    localparam int         SIR_TICKS_PER_BIT = 16;
    localparam logic [3:0] SIR_LAST_TICK     = 4'd15;

    typedef enum logic {
        SIR_DEC_IDLE,
        SIR_DEC_STRETCH
    } sir_dec_state_t;

endpackage

// File: rtl/irda_sir_decoder_if.sv
// rtl/irda_sir_decoder_if.sv - SIR receive-path signal bundle between link control/transceiver and decoder
interface irda_sir_decoder_if;

    logic fast_mode;
    logic fast_enable;
    logic rx_select;
    logic sir_dec_i;
    logic srx_pad_i;
    logic rx_active_o;
    logic pulse_err_o;

    modport master (
        output fast_mode, fast_enable, rx_select, sir_dec_i,
        input  srx_pad_i, rx_active_o, pulse_err_o
    );

    modport slave (
        input  fast_mode, fast_enable, rx_select, sir_dec_i,
        output srx_pad_i, rx_active_o, pulse_err_o
    );

endinterface

// File: rtl/irda_sir_glitch_filter.sv
// rtl/irda_sir_glitch_filter.sv - synchronizer, glitch filter and rising-edge detect (IRDA_SIR_DEC_INVERT_EN inverts input)
module irda_sir_glitch_filter
    import irda_pkg::*;
#(
    parameter int GLITCH_CYC = 2
) (
    input  logic clk,
    input  logic wb_rst_n_i,
    input  logic clear,
    input  logic sir_dec_i,
    output logic q,
    output logic det
);

    localparam logic [3:0] GLITCH_M1 = 4'(GLITCH_CYC - 1);

    logic       raw;
    logic       sync1;
    logic       s;
    logic       q_prev;
    logic       armed;
    logic [3:0] gcnt;

`ifdef IRDA_SIR_DEC_INVERT_EN
    assign raw = ~sir_dec_i;
`else
    assign raw = sir_dec_i;
`endif

    // Synchronizer ignores clear so the line state is known on re-enable.
    always_ff @(posedge clk) begin
        if (!wb_rst_n_i) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (!wb_rst_n_i || clear) begin
            gcnt   <= 4'd0;
            q      <= 1'b0;
            q_prev <= 1'b0;
            armed  <= 1'b0;
        end else begin
            q_prev <= q;
            if (!s) begin
                gcnt  <= 4'd0;
                q     <= 1'b0;
                armed <= 1'b1;
            end else begin
                if (gcnt != 4'd15) begin
                    gcnt <= gcnt + 4'd1;
                end
                q <= (gcnt >= GLITCH_M1);
            end
        end
    end

    // armed blocks a detect when light was already present at enable time.
    assign det = q & ~q_prev & armed;

endmodule

// File: rtl/irda_sir_decoder.sv
// rtl/irda_sir_decoder.sv - IrDA SIR pulse to UART NRZ decoder (option IRDA_SIR_DEC_INVERT_EN)
module irda_sir_decoder
    import irda_pkg::*;
#(
    parameter int GLITCH_CYC      = 2,
    parameter int MAX_PULSE_TICKS = 8
) (
    input  logic         clk,
    input  logic         wb_rst_n_i,
    irda_sir_decoder_if.slave dec
);

    localparam int             WW   = $clog2(MAX_PULSE_TICKS + 1);
    localparam logic [WW-1:0]  WMAX = WW'(MAX_PULSE_TICKS);
    localparam logic [WW-1:0]  WONE = WW'(1);

    logic           clear;
    logic           q;
    logic           det;
    sir_dec_state_t state;
    sir_dec_state_t state_nx;
    logic [3:0]     bitcnt;
    logic [3:0]     bitcnt_nx;
    logic           srx;
    logic           srx_nx;
    logic           act;
    logic           act_nx;
    logic [WW-1:0]  wcnt;
    logic           err;

    assign clear = dec.fast_mode | ~dec.rx_select;

    irda_sir_glitch_filter #(
        .GLITCH_CYC (GLITCH_CYC)
    ) u_filter (
        .clk        (clk),
        .wb_rst_n_i (wb_rst_n_i),
        .clear      (clear),
        .sir_dec_i  (dec.sir_dec_i),
        .q          (q),
        .det        (det)
    );

    always_ff @(posedge clk) begin
        if (!wb_rst_n_i || clear) begin
            state  <= SIR_DEC_IDLE;
            bitcnt <= 4'd0;
            srx    <= 1'b1;
            act    <= 1'b0;
        end else begin
            state  <= state_nx;
            bitcnt <= bitcnt_nx;
            srx    <= srx_nx;
            act    <= act_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        bitcnt_nx = bitcnt;
        srx_nx    = srx;
        act_nx    = act;
        case (state)
            SIR_DEC_IDLE: begin
                srx_nx = 1'b1;
                act_nx = 1'b0;
                if (det) begin
                    state_nx  = SIR_DEC_STRETCH;
                    bitcnt_nx = 4'd0;
                    srx_nx    = 1'b0;
                    act_nx    = 1'b1;
                end
            end
            SIR_DEC_STRETCH: begin
                srx_nx = 1'b0;
                act_nx = 1'b1;
                // A retrigger takes priority over a coincident tick so back-to-back zeros stay low.
                if (det) begin
                    bitcnt_nx = 4'd0;
                end else if (dec.fast_enable) begin
                    if (bitcnt == SIR_LAST_TICK) begin
                        state_nx  = SIR_DEC_IDLE;
                        bitcnt_nx = 4'd0;
                        srx_nx    = 1'b1;
                        act_nx    = 1'b0;
                    end else begin
                        bitcnt_nx = bitcnt + 4'd1;
                    end
                end
            end
            default: begin
                state_nx = SIR_DEC_IDLE;
            end
        endcase
    end

    // Width monitor saturates so a long pulse reports exactly once.
    always_ff @(posedge clk) begin
        if (!wb_rst_n_i || clear) begin
            wcnt <= '0;
            err  <= 1'b0;
        end else begin
            err <= 1'b0;
            if (!q) begin
                wcnt <= '0;
            end else if (dec.fast_enable && (wcnt != WMAX)) begin
                wcnt <= wcnt + WONE;
                if (wcnt == (WMAX - WONE)) begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign dec.srx_pad_i   = srx;
    assign dec.rx_active_o = act;
    assign dec.pulse_err_o = err;

endmodule

// File: tb/tb_irda_sir_decoder.sv
// tb/tb_irda_sir_decoder.sv - self-checking bench for irda_sir_decoder
module tb_irda_sir_decoder;

    localparam int G    = 2;
    localparam int MAXP = 8;
    localparam int HN   = 8192;
`ifdef IRDA_SIR_DEC_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic clk = 1'b0;
    logic wb_rst_n_i;

    irda_sir_decoder_if bus ();

    irda_sir_decoder #(
        .GLITCH_CYC      (G),
        .MAX_PULSE_TICKS (MAXP)
    ) dut (
        .clk        (clk),
        .wb_rst_n_i (wb_rst_n_i),
        .dec        (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic srx_h [HN];
    logic err_h [HN];

    // Model state: synchronized line, qualified-light history, dark-seen flag, stretch window.
    logic m_sy1 = 1'b0, m_sy2 = 1'b0;
    logic qh1 = 1'b0, qh2 = 1'b0, arm1 = 1'b0, str = 1'b0;
    int   run_len = 0, lt = 0, tc = 0;
    logic exp_srx = 1'b1, exp_act = 1'b0, exp_err = 1'b0, mvalid = 1'b0;
    logic m_en, m_s, m_det, m_qn, m_arm, m_tick;

    task automatic chk_bit(input string nm, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, expv);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, expv);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        m_en   = wb_rst_n_i && !bus.fast_mode && bus.rx_select;
        m_s    = m_sy2;
        m_tick = bus.fast_enable;
        m_det  = m_en && qh1 && !qh2 && arm1;
        if (!m_en || !qh1) begin
            lt = 0; exp_err = 1'b0;
        end else if (m_tick) begin
            lt++; exp_err = (lt == MAXP);
        end else begin
            exp_err = 1'b0;
        end
        if (!m_en) begin
            str = 1'b0;
        end else if (m_det) begin
            str = 1'b1; tc = 0;
        end else if (str && m_tick) begin
            tc++;
            if (tc == 16) str = 1'b0;
        end
        if (!m_en || !m_s) run_len = 0;
        else if (run_len < 100) run_len++;
        m_qn  = (run_len >= G);
        m_arm = m_en && (!m_s || arm1);
        qh2 = qh1; qh1 = m_qn; arm1 = m_arm;
        m_sy2 = wb_rst_n_i ? m_sy1 : 1'b0;
        m_sy1 = wb_rst_n_i ? (bus.sir_dec_i ^ INV) : 1'b0;
        exp_srx = !str;
        exp_act = str;
        mvalid  = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (cyc < HN) begin
            srx_h[cyc] = bus.srx_pad_i;
            err_h[cyc] = bus.pulse_err_o;
        end
        if (mvalid) begin
            chk_bit("srx_model", bus.srx_pad_i, exp_srx);
            chk_bit("active_model", bus.rx_active_o, exp_act);
            chk_bit("err_model", bus.pulse_err_o, exp_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.fast_enable = ((cyc + 1) % 4 == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic align3();
        step();
        while (cyc % 4 != 3) step();
    endtask

    task automatic set_light(input logic b);
        bus.sir_dec_i = b ^ INV;
    endtask

    function automatic int first_low(input int a, input int b);
        for (int c = a; c < b && c < HN; c++) if (srx_h[c] === 1'b0) return c;
        return -1;
    endfunction

    function automatic int low_len(input int a);
        int n = 0;
        if (a < 0) return -1;
        for (int c = a; c < HN && n < 2000; c++) begin
            if (srx_h[c] !== 1'b0) break;
            n++;
        end
        return n;
    endfunction

    function automatic int count_low(input int a, input int b);
        int n = 0;
        for (int c = a; c < b && c < HN; c++) if (srx_h[c] === 1'b0) n++;
        return n;
    endfunction

    function automatic int count_err(input int a, input int b);
        int n = 0;
        for (int c = a; c < b && c < HN; c++) if (err_h[c] === 1'b1) n++;
        return n;
    endfunction

    task automatic send_frame(input logic [7:0] data, output int k);
        logic [9:0] fr;
        fr = {1'b1, data, 1'b0};
        align3();
        k = cyc;
        for (int i = 0; i < 10; i++) begin
            if (!fr[i]) begin
                set_light(1'b1); run(12); set_light(1'b0); run(52);
            end else begin
                run(64);
            end
        end
        run(100);
    endtask

    int   k, k2, f;
    logic exp55 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        wb_rst_n_i      = 1'b0;
        bus.fast_mode   = 1'b0;
        bus.rx_select   = 1'b1;
        bus.fast_enable = 1'b0;
        bus.sir_dec_i   = 1'b0;

        for (int i = 0; i < 4; i++) begin
            step();
            bus.sir_dec_i = ~bus.sir_dec_i;
        end
        wb_rst_n_i = 1'b1;
        run(8);
        for (int c = 1; c <= 5; c++) begin
            chk_bit("reset_srx", srx_h[c], 1'b1);
            chk_bit("reset_err", err_h[c], 1'b0);
        end

        // Single 3-tick pulse
        align3(); k = cyc;
        set_light(1'b1); run(12); set_light(1'b0); run(100);
        f = first_low(k, k + 20);
        chk_int("single_latency", f - k, 5);
        chk_int("single_low_len", low_len(f), 64);
        chk_int("single_no_err", count_err(k, cyc), 0);

        // One-clock glitch
        align3(); k = cyc;
        set_light(1'b1); run(1); set_light(1'b0); run(20);
        chk_int("glitch_no_low", count_low(k, cyc), 0);

        // Frame 0x55
        send_frame(8'h55, k);
        for (int i = 0; i < 10; i++) chk_bit("frame55_bit", srx_h[k + 5 + 32 + 64 * i], exp55[i]);

        // Frame 0x00: continuous low across start + 8 data bits
        send_frame(8'h00, k);
        chk_int("frame00_low_len", low_len(k + 5), 576);
        chk_bit("frame00_stop", srx_h[k + 5 + 576], 1'b1);

        // Long pulse of 10 ticks
        align3(); k = cyc;
        set_light(1'b1); run(40); set_light(1'b0); run(80);
        chk_int("long_err_count", count_err(k, cyc), 1);
        chk_bit("long_err_on_8th_tick", err_h[k + 33], 1'b1);
        chk_int("long_low_len", low_len(k + 5), 64);

        // fast_mode mid-stretch, then re-enable with light still on
        align3(); k = cyc;
        set_light(1'b1); run(20);
        k2 = cyc;
        bus.fast_mode = 1'b1;
        run(10);
        chk_bit("fast_before", srx_h[k2], 1'b0);
        chk_bit("fast_cleared", srx_h[k2 + 1], 1'b1);
        bus.fast_mode = 1'b0;
        run(20);
        chk_int("reenable_no_detect", count_low(k2 + 1, cyc), 0);
        set_light(1'b0); run(10);
        align3(); k = cyc;
        set_light(1'b1); run(12); set_light(1'b0); run(8);
        chk_int("reenable_latency", first_low(k, k + 20) - k, 5);

        // rx_select drop mid-stretch
        k2 = cyc;
        bus.rx_select = 1'b0;
        run(3);
        bus.rx_select = 1'b1;
        run(80);
        chk_bit("rxsel_before", srx_h[k2], 1'b0);
        chk_bit("rxsel_cleared", srx_h[k2 + 1], 1'b1);

        run(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irda_sir_decoder.md
Name: irda_sir_decoder

Overview:
- Receive-side counterpart of the SIR transmit encoder. Converts raw IrDA SIR light pulses into a UART-level NRZ stream for the UART receiver.
- A pulse means a '0' bit. No pulse means a '1' bit.
- Sits between the IR transceiver RX pin and the UART srx input. Clocked from the system clock and paced by the same 16x-baud fast_enable tick the encoder uses.
- Idle whenever fast mode (MIR/FIR) owns the link.

Parameters:
- GLITCH_CYC, 2: consecutive clk cycles the synchronized input must be high before a pulse is accepted. Legal range 1..15.
- MAX_PULSE_TICKS, 8: fast_enable ticks of continuous light after which a pulse is flagged as too long.

Ports:
- clk  in  1  system clock
- wb_rst_n_i  in  1  reset. Synchronous, active-low.
- fast_mode  in  1  1 = MIR/FIR active; decoder held cleared.
- fast_enable  in  1  16x baud tick, one clk wide.
- rx_select  in  1  1 = SIR receive path enabled.
- sir_dec_i  in  1  raw asynchronous transceiver output; high = light.
- srx_pad_i  out  1  recovered UART serial data; idle 1.
- rx_active_o  out  1  high while a '0' bit is being stretched.
- pulse_err_o  out  1  one-clk strobe when a pulse exceeds MAX_PULSE_TICKS.

Behaviour:
- Reset (wb_rst_n_i=0 at posedge clk) clears everything: srx_pad_i=1, rx_active_o=0, pulse_err_o=0. Synchronizer flops=0, all counters=0, armed=0, FSM=IDLE.
- Synchronizer: 2 flops on sir_dec_i, producing s.
- Glitch filter:
  - gcnt counts clk cycles while s=1 and clears on s=0.
  - Qualified level q is registered. q asserts on the GLITCH_CYC-th consecutive clk with s=1 and deasserts on the first clk with s=0.
- Arming: armed sets on any clk with s=0.
- Pulse detect: det = q & ~q_prev & armed (combinational strobe).
- Latency: sir_dec_i rise to srx_pad_i fall is 2 + GLITCH_CYC + 1 clk; 5 clk at default.
- FSM states:
  - IDLE: srx_pad_i=1, rx_active_o=0. On det: go to STRETCH, bitcnt=0, srx_pad_i<=0, rx_active_o<=1.
  - STRETCH: srx_pad_i=0. Each fast_enable increments the 4-bit bitcnt.
    - fast_enable with bitcnt==15 and no det: go to IDLE, srx_pad_i<=1. The low window is therefore exactly 16 ticks.
    - det: bitcnt<=0 (retrigger), stay in STRETCH, srx_pad_i stays 0. Back-to-back '0' bits give continuous low with no 1-clk gap.
    - det and fast_enable in the same clk: det wins, bitcnt=0.
- Width monitor:
  - wcnt counts fast_enable ticks while q=1 and clears when q=0.
  - On the tick where wcnt reaches MAX_PULSE_TICKS, pulse_err_o pulses for 1 clk. wcnt then saturates; no further strobe until q falls.
  - The stretch window is not extended by a long pulse: srx_pad_i returns to 1 after 16 ticks even if light persists.
- Disable (fast_mode=1 or rx_select=0), evaluated at each clk:
  - Synchronous clear of gcnt, q, armed, bitcnt, wcnt and FSM to the reset values. Outputs return to the reset values on the next clk.
  - The synchronizer keeps sampling.
  - fast_mode has priority over rx_select. Reset has priority over both.
- Re-enable mid-pulse: armed=0, so no detection occurs until s has been seen low, then a new rise.
- All counters are fixed width. bitcnt wraps only via the IDLE transition, never silently.

Optional Feature:
- Macro IRDA_SIR_DEC_INVERT_EN.
- Defined: sir_dec_i is inverted before the first synchronizer flop, for active-low transceivers (low = light). Synchronizer reset value is unchanged (post-inversion 0 = dark).
- Undefined: sir_dec_i is used as is (high = light).
- All other behaviour is identical either way.

Decomposition:
- Shared package irda_pkg holds:
  - SIR_TICKS_PER_BIT=16 and SIR_LAST_TICK=15, also used by the encoder.
  - Decoder state enum {SIR_DEC_IDLE, SIR_DEC_STRETCH}.
- One sub-module, irda_sir_glitch_filter:
  - Contains the synchronizer, gcnt, q, armed and det.
  - Exports q and det.
  - Takes the clear input and the GLITCH_CYC parameter.
- Top level holds the FSM, bitcnt and the width monitor.

Test Plan:
- Reset: wb_rst_n_i=0 for 4 clk with sir_dec_i toggling -> srx_pad_i=1, rx_active_o=0, pulse_err_o=0 throughout and 1 clk after release.
- Single pulse, GLITCH_CYC=2, tick every 4 clk, sir_dec_i high 12 clk (3 ticks) -> srx_pad_i falls 5 clk after the rise, stays low exactly 16 ticks (64 clk), rx_active_o equals ~srx_pad_i, no pulse_err_o.
- Glitch: sir_dec_i high for 1 clk -> no change on any output.
- UART frame for 0x55 with the start bit pulsed and pulses on '0' bits at 16-tick spacing -> srx_pad_i = 0,1,0,1,0,1,0,1,0,1 per 16-tick bit. A second test with 0x00 gives a continuous low across 9 bits with no glitch at retrigger.
- Long pulse held 10 ticks, MAX_PULSE_TICKS=8 -> exactly one pulse_err_o strobe on the 8th tick; srx_pad_i back to 1 after 16 ticks.
- fast_mode=1 mid-STRETCH -> srx_pad_i=1 next clk. Deassert fast_mode while sir_dec_i is still high -> no detect; drop sir_dec_i, raise again -> detect with normal latency.
